booth_seq_mult: RTL
===================

// Module: booth_seq_mult
// PURPOSE
//  Iterative radix-2 Booth multiplier: one Booth add/sub + arithmetic shift per clock.
//  Parametrised successor to the combinational unrolled Booth array; trades latency for area.
//  Supports runtime signed/unsigned mode and uses valid/ready handshakes on input and output.
//  Sits between operand issue logic and result writeback in the multiplier datapath.
// PARAMETERS
//  WIDTH   16  operand width in bits; product is 2*WIDTH bits; legal range 4..64
// PORTS
//  clk            in   1         rising-edge clock
//  rst            in   1         asynchronous reset, active-high
//  in_valid       in   1         operands and mode are valid
//  in_ready       out  1         block can accept operands (high only in IDLE)
//  is_signed      in   1         1: two's-complement operands; 0: unsigned operands
//  multiplicand   in   WIDTH     operand M
//  multiplier     in   WIDTH     operand Q
//  out_valid      out  1         product is valid (high only in DONE)
//  out_ready      in   1         consumer accepts product
//  product        out  2*WIDTH   M*Q, interpreted per the latched is_signed
//  busy           out  1         high in RUN
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0,
//   and all internal registers=0. An in-flight operation is discarded and never reported.
//  States: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after WIDTH+1 steps;
//   DONE -> IDLE on out_valid&&out_ready. No other transitions occur.
//  Load (accept edge):
//   - Extend M and Q to WIDTH+1 bits: sign-extend when is_signed=1, zero-extend otherwise.
//   - A=0, width WIDTH+2 (guard bit; no overflow is possible); q_1=0; step count=0.
//   - is_signed is latched; later changes to the input have no effect on this operation.
//  RUN step (one per clock):
//   - {Q[0],q_1}=01: A=A+M; =10: A=A-M; =00 or 11: A unchanged.
//   - Then arithmetic right shift of {A,Q,q_1} by 1; the A MSB is replicated.
//   - The step count increments. After the step with count==WIDTH (WIDTH+1 steps in
//     total), the next state is DONE.
//  Result: product = low 2*WIDTH bits of {A,Q} after the final step. It is registered
//   and stable for the whole of DONE.
//  Latency: for an accept edge E0, out_valid is first high in the cycle after edge
//   E0+WIDTH+1. For WIDTH=16 this is 17 cycles. Throughput is 1 product per WIDTH+3
//   cycles with out_ready held high.
//  Handshake rules:
//   - in_ready=0 in RUN and DONE; in_valid in those states is ignored and nothing is queued.
//   - out_valid stays high and product holds until out_ready=1; there is no timeout.
//   - in_ready returns high the cycle after output acceptance; there is no same-cycle
//     accept-and-load.
//  Edge cases:
//   - Operand 0, all-ones, and most-negative values are all handled by the WIDTH+1 extension.
//   - Signed most-negative*most-negative gives the exact positive result.
// TESTING
//  1 WIDTH=16 unsigned 0xFFFF*0xFFFF -> product 0xFFFE0001; out_valid first high 17 cycles
//    after accept.
//  2 WIDTH=16 signed 0x8000*0x8000 -> 0x40000000. Signed 0xFFFF*0x0001 -> 0xFFFFFFFF.
//    Signed 0x8000*0x7FFF -> 0xC0008000.
//  3 Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and product stable
//    throughout. With in_valid=1 and new operands the whole time -> in_ready stays 0 and
//    the result is unchanged.
//  4 Mode latch: accept 0xFFFF*0x0002 with is_signed=0, toggle is_signed during RUN ->
//    0x0001FFFE.
//  5 Assert rst at step 8 of a run -> next cycle: IDLE, in_ready=1, out_valid=0,
//    product=0. A fresh 3*5 then gives 15.
//  6 WIDTH=8: unsigned 200*3 -> 600 (0x0258), latency 9. Random signed and unsigned
//    10k-operation sweep against a reference model, with randomized out_ready.

Source files
------------

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative radix-2 Booth multiplier, one add/sub + shift per clock
module booth_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH+1:0] a, m, sum;
  logic [WIDTH:0] q;
  logic q_1;
  logic [CW-1:0] cnt;
  logic [2*WIDTH+3:0] shifted;
  logic last;
  assign in_ready  = state == IDLE;
  assign busy      = state == RUN;
  assign out_valid = state == DONE;
  assign last      = cnt == CW'(WIDTH);
  // Booth add/sub then arithmetic shift of {A,Q,q_1}; shifting drops the old q_1
  always_comb begin
    sum = ({q[0], q_1} == 2'b01) ? a + m : ({q[0], q_1} == 2'b10) ? a - m : a;
    shifted = {sum[WIDTH+1], sum, q};
  end
  // next-state: WIDTH+1 steps in RUN, hold DONE until the consumer takes the product
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? RUN : IDLE;
      RUN:  state_n = last ? DONE : RUN;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // datapath: load extended operands on accept, step while running, capture result on last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      m <= '0;
      q <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
      product <= '0;
    end else if (state == IDLE && in_valid) begin
      a <= '0;
      m <= {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
      q <= {is_signed & multiplier[WIDTH-1], multiplier};
      q_1 <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      a <= shifted[2*WIDTH+3:WIDTH+2];
      q <= shifted[WIDTH+1:1];
      q_1 <= shifted[0];
      cnt <= cnt + 1'b1;
      if (last) product <= shifted[2*WIDTH:1];
    end
  end
endmodule
